// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 byte-TX core between NUM_REQ byte sources.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_send_go,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 tx_timeout
);

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] pick;
  logic            found;

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0]     wd_cnt;
`endif

  // The round-robin pointer is always the most recent grant, so it doubles as grant_id.
  assign grant_id = ptr;

  // Search starts just after the last winner and wraps, giving rotating priority.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req_valid[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      ptr        <= ID_W'(NUM_REQ - 1);
      req_ack    <= '0;
      tx_send_go <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      tx_timeout <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      req_ack    <= '0;
      tx_send_go <= 1'b0;
      tx_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            tx_data    <= req_data[int'(pick)*8 +: 8];
            ptr        <= pick;
            req_ack    <= NUM_REQ'(1) << pick;
            tx_send_go <= 1'b1;
            busy       <= 1'b1;
            state      <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
          end
        end
        WAIT_DONE: begin
          // A tx_done coinciding with our own launch pulse belongs to the previous byte.
          if (tx_done && !tx_send_go) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            busy       <= 1'b0;
            tx_timeout <= 1'b1;
            state      <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART byte transmitter (8N1 byte-TX core) between NUM_REQ byte sources.
- Captures one byte from the granted requester and launches it with a one-cycle send pulse. Holds tx_data stable until the core reports tx_done, then re-arbitrates.
- Sits between the application message generators and the single physical uart_tx pin path. Runs on the 50 MHz system clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must equal clog2(NUM_REQ).
- TIMEOUT_CYCLES, 60000, watchdog limit in Clk cycles (one 9600-baud 8N1 byte is 52083 cycles). Used only with UART_ARB_TIMEOUT_EN.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  bit i high = requester i has a byte pending.
- req_data  in  NUM_REQ*8  byte of requester i on bits [8i+7:8i].
- req_ack  out  NUM_REQ  one-cycle pulse on bit i = requester i's byte was captured.
- tx_send_go  out  1  one-cycle launch pulse to the byte-TX core.
- tx_data  out  8  byte to the TX core; stable from tx_send_go until tx_done.
- tx_done  in  1  one-cycle completion pulse from the TX core (after stop bit).
- grant_id  out  ID_W  index of the current or most recent grant.
- busy  out  1  high while a byte is in flight.
- tx_timeout  out  1  one-cycle watchdog error pulse (see Optional Feature).

Behaviour:
- Reset (Reset_n low at a rising edge):
  - State goes to IDLE.
  - req_ack, tx_send_go, tx_data, busy and tx_timeout all go to 0.
  - grant_id goes to NUM_REQ-1, and the round-robin pointer goes to NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE and WAIT_DONE.
- IDLE, at an edge with req_valid != 0:
  - Select the first set bit searching (ptr+1), (ptr+2), ... mod NUM_REQ. Call it g.
  - Capture req_data[g] into tx_data. Set grant_id=g and ptr=g. Go to WAIT_DONE.
  - In the following cycle, req_ack[g]=1, tx_send_go=1 and busy=1, all for exactly one cycle except busy.
- Latency: req_valid sampled high at edge k gives req_ack and tx_send_go high in cycle k+1.
- Requester contract:
  - Hold req_valid and req_data stable until req_ack is seen.
  - At the edge ending the ack cycle, either drop req_valid or present the next byte.
  - A requester deasserting req_valid before its ack is a protocol violation; behaviour is undefined.
- WAIT_DONE:
  - tx_done is ignored during the tx_send_go cycle itself (stale pulse from the core).
  - tx_done sampled high in any later cycle: go to IDLE and set busy=0 from the next cycle.
  - Earliest next acceptance is that same IDLE cycle's edge. Back-to-back bytes therefore see one idle cycle between tx_done and the next tx_send_go.
- Outside WAIT_DONE:
  - tx_done in IDLE is ignored.
  - req_valid changes in WAIT_DONE are ignored; there is no preemption.
- Fairness: a requester whose valid stays high is served at most once every NUM_REQ grants while the others also request.
- tx_data and grant_id hold their last values in IDLE; they are not cleared.
- Reset mid-transfer: the in-flight byte is abandoned with no ack replay. The TX core shares Reset_n and aborts as well.
- All outputs are registered. There are no combinational paths from req_valid or tx_done to the outputs.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 32-bit counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - If it reaches TIMEOUT_CYCLES-1 without tx_done, the block returns to IDLE.
  - tx_timeout pulses high for one cycle together with busy=0. The byte is dropped (already acked), and the pointer still advances past g.
  - If tx_done and expiry occur in the same cycle, tx_done wins and there is no timeout pulse.
- Without the macro: there is no counter, WAIT_DONE waits indefinitely, and tx_timeout is tied to 0.

Test Plan:
- Reset then idle, tx_done pulsed spuriously -> all outputs 0, grant_id=3, state stays IDLE, no tx_send_go.
- Only requester 2 valid with 0x55, tx_done returned 20 cycles after tx_send_go -> req_ack=4'b0100 and tx_send_go one cycle after capture, tx_data=0x55, busy high 21 cycles.
- All four valid continuously (0x41,0x42,0x43,0x44), core model answering tx_done after 10 cycles -> tx_data sequence 0x41,0x42,0x43,0x44,0x41, grant_id 0,1,2,3,0, one idle cycle between bytes.
- tx_done asserted in the same cycle as tx_send_go, then again 5 cycles later -> first pulse ignored, IDLE reached only after the second.
- Reset_n driven low for 1 cycle mid-WAIT_DONE with requester 1 still valid -> outputs cleared, then requester 1 re-acked after reset with pointer restarted (requester 0 first if also valid).
- UART_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=50, tx_done never returned -> tx_timeout pulse 50 cycles after entering WAIT_DONE, busy=0, next requester granted; without the macro busy stays 1 indefinitely.
